chip_layer_responder: RTL

//  Chip-side responder for the start_layer / done_layer handshake driven by the network controller.

---
 rtl/chip_if_pkg.sv | 14 +
 rtl/layer_lat_table.sv | 24 ++
 rtl/chip_layer_responder.sv | 109 ++++++++++
 3 files changed

// File: rtl/chip_if_pkg.sv
// Shared types and widths for the chip-side layer responder.
// Purely declarative: no timing or flow-control content.
package chip_if_pkg;

  localparam int LAYER_W   = 6;
  localparam int LAT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_STORE = 2'd2
  } state_t;

endpackage

// File: rtl/layer_lat_table.sv
// Per-layer latency table: synchronous write, asynchronous read.
// Zero read latency; writes land on the clock edge, so a same-edge read returns the old value.
module layer_lat_table #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int DW    = 16
) (
  input  logic          chip_clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge chip_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/chip_layer_responder.sv
// Emulates chip layer/store execution for start_layer / start_store_byte4 request edges.
// done_layer pulses L cycles after the accepting edge; requests arriving while busy are dropped and flagged.
module chip_layer_responder
  import chip_if_pkg::*;
#(
  parameter int MAX_LAYERS   = 64,
  parameter int LAT_W        = LAT_W_DEF,
  parameter int STORE_CYCLES = 4
) (
  input  logic               chip_clk,
  input  logic               rstn,
  input  logic               start_layer,
  input  logic               start_store_byte4,
  input  logic [LAYER_W-1:0] n_layers,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_addr,
  input  logic [LAT_W-1:0]   cfg_wdata,
  output logic               done_layer,
  output logic               busy,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               err_overlap
);

  localparam logic [LAT_W-1:0] STORE_LOAD = LAT_W'(STORE_CYCLES - 1);

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic               start_layer_q, store_q;
  logic               req_l, req_s;
  logic               done_d, err_d;
  logic [LAYER_W-1:0] idx_d;
  logic [LAYER_W-1:0] last_idx;
  logic [LAT_W-1:0]   lat_raw, lat_eff;

  layer_lat_table #(
    .DEPTH (MAX_LAYERS),
    .AW    (LAYER_W),
    .DW    (LAT_W)
  ) u_lat_table (
    .chip_clk (chip_clk),
    .we       (cfg_we),
    .waddr    (cfg_addr),
    .wdata    (cfg_wdata),
    .raddr    (layer_idx),
    .rdata    (lat_raw)
  );

  assign req_l    = start_layer & ~start_layer_q;
  assign req_s    = start_store_byte4 & ~store_q;
  // A zero entry still costs one cycle, so unprogrammed layers complete.
  assign lat_eff  = (lat_raw == '0) ? LAT_W'(1) : lat_raw;
  assign last_idx = (n_layers == '0) ? '0 : n_layers - LAYER_W'(1);
  assign busy     = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    idx_d   = layer_idx;
    err_d   = err_overlap;
    case (state_q)
      S_IDLE: begin
        if (req_l) begin
          state_d = S_RUN;
          cnt_d   = lat_eff - LAT_W'(1);
          if (req_s) err_d = 1'b1;
        end else if (req_s) begin
          state_d = S_STORE;
          cnt_d   = STORE_LOAD;
        end
      end
      S_RUN, S_STORE: begin
        if (req_l || req_s) err_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - LAT_W'(1);
        end else begin
          done_d  = 1'b1;
          state_d = S_IDLE;
          if (state_q == S_RUN)
            idx_d = (layer_idx == last_idx) ? '0 : layer_idx + LAYER_W'(1);
          else
            idx_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge chip_clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      start_layer_q <= 1'b0;
      store_q       <= 1'b0;
      done_layer    <= 1'b0;
      layer_idx     <= '0;
      err_overlap   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      start_layer_q <= start_layer;
      store_q       <= start_store_byte4;
      done_layer    <= done_d;
      layer_idx     <= idx_d;
      err_overlap   <= err_d;
    end
  end

endmodule
